lsu_align: RTL and testbench

LSU_ALIGN -- requirements
Module: lsu_align

---
 rtl/lsu_align.sv | 174 +++++++++++++++++
 tb/tb_lsu_align.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// Load/store alignment unit for a 64-bit word memory: merges sub-word stores by
// read-modify-write and extracts/extends sub-word loads.
module lsu_align (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        stall,
    output logic [63:0] load_data,
    output logic        load_valid,
    output logic        misaligned,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wd,
    input  logic [63:0] mem_rd
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD_WAIT = 2'd1;
    localparam logic [1:0] RMW_WRITE = 2'd2;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [63:0] addr_r;
    logic [63:0] wdata_r;
    logic [2:0]  funct3_r;
    logic [63:0] load_data_r;
    logic        load_valid_r;
    logic        misaligned_r;
    logic        legal_s;
    logic        aligned_s;
    logic        stall_s;
    logic        we_s;
    logic [63:0] addr_s;
    logic [63:0] wd_s;

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] m;
        case (size)
            2'b00:   m = 64'h0000_0000_0000_00FF;
            2'b01:   m = 64'h0000_0000_0000_FFFF;
            2'b10:   m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // Replace the byte lanes starting at offset with the low bytes of src.
    function automatic logic [63:0] merge_lanes(input logic [63:0] old_word,
                                                input logic [63:0] src,
                                                input logic [2:0]  offset,
                                                input logic [1:0]  size);
        logic [5:0]  sh;
        logic [63:0] lane_mask;
        sh        = {offset, 3'b000};
        lane_mask = size_mask(size) << sh;
        return (old_word & ~lane_mask) | ((src & size_mask(size)) << sh);
    endfunction

    function automatic logic [63:0] extract_load(input logic [63:0] word,
                                                 input logic [2:0]  offset,
                                                 input logic [2:0]  code);
        logic [63:0] s;
        logic [63:0] r;
        s = word >> {offset, 3'b000};
        case (code[1:0])
            2'b00:   r = {{56{s[7]  & ~code[2]}}, s[7:0]};
            2'b01:   r = {{48{s[15] & ~code[2]}}, s[15:0]};
            2'b10:   r = {{32{s[31] & ~code[2]}}, s[31:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    // Request classification: legality and natural alignment of the incoming access.
    always_comb begin
        legal_s = req_we ? ~funct3[2] : (funct3 != 3'b111);
        case (funct3[1:0])
            2'b00:   aligned_s = 1'b1;
            2'b01:   aligned_s = ~addr[0];
            2'b10:   aligned_s = ~|addr[1:0];
            default: aligned_s = ~|addr[2:0];
        endcase
    end

    // Next-state and memory-port decode; the reset gating is applied on the outputs below.
    always_comb begin
        stall_s     = 1'b0;
        we_s        = 1'b0;
        addr_s      = addr;
        wd_s        = 64'd0;
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid && legal_s && aligned_s) begin
                    if (req_we && (funct3[1:0] == 2'b11)) begin
                        we_s        = 1'b1;
                        wd_s        = wdata;
                        state_nxt_s = IDLE;
                    end else begin
                        stall_s     = 1'b1;
                        state_nxt_s = req_we ? RMW_WRITE : LOAD_WAIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD_WAIT: begin
                addr_s      = addr_r;
                state_nxt_s = IDLE;
            end
            RMW_WRITE: begin
                we_s        = 1'b1;
                addr_s      = addr_r;
                wd_s        = merge_lanes(mem_rd, wdata_r, addr_r[2:0], funct3_r[1:0]);
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Reset must silence the write strobe immediately so an aborted RMW never lands.
    assign stall      = rst_n & stall_s;
    assign mem_we     = rst_n & we_s;
    assign mem_addr   = addr_s;
    assign mem_wd     = mem_we ? wd_s : 64'd0;
    assign load_data  = load_data_r;
    assign load_valid = load_valid_r;
    assign misaligned = misaligned_r;

    // FSM state and the request copy latched at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            addr_r   <= 64'd0;
            wdata_r  <= 64'd0;
            funct3_r <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == IDLE) && stall_s) begin
                addr_r   <= addr;
                wdata_r  <= wdata;
                funct3_r <= funct3;
            end else begin
                addr_r   <= addr_r;
                wdata_r  <= wdata_r;
                funct3_r <= funct3_r;
            end
        end
    end

    // Load result, its valid pulse and the misalignment fault pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_data_r  <= 64'd0;
            load_valid_r <= 1'b0;
            misaligned_r <= 1'b0;
        end else begin
            load_valid_r <= (state_r == LOAD_WAIT);
            misaligned_r <= (state_r == IDLE) && req_valid && legal_s && !aligned_s;
            if (state_r == LOAD_WAIT) begin
                load_data_r <= extract_load(mem_rd, addr_r[2:0], funct3_r);
            end else begin
                load_data_r <= load_data_r;
            end
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: directed vector table, reset-abort sequence and random
// traffic checked against a byte-addressed reference memory.
module tb_lsu_align;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        stall;
    logic [63:0] load_data;
    logic        load_valid;
    logic        misaligned;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wd;
    logic [63:0] mem_rd;

    lsu_align dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
        .load_data(load_data), .load_valid(load_valid), .misaligned(misaligned),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory seen by the DUT (environment), with a preload port used during reset.
    logic [63:0] tmem [0:31];
    logic        pl_we;
    logic [4:0]  pl_idx;
    logic [63:0] pl_data;
    always @(posedge clk) begin
        if (pl_we) tmem[pl_idx] <= pl_data;
        else if (mem_we) tmem[mem_addr[7:3]] <= mem_wd;
        mem_rd <= tmem[mem_addr[7:3]];
    end

    // Reference model: flat byte memory plus bench-side expectations.
    logic [7:0]  refmem [0:255];
    logic [63:0] last_ld;
    logic [63:0] obs_wd;
    logic        prev_lv;
    logic        prev_mis;
    int          total;
    int          bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_word(input logic [63:0] a);
        logic [63:0] w;
        int base;
        base = int'({a[7:3], 3'b000});
        for (int i = 0; i < 8; i++) w[8*i +: 8] = refmem[8'(base + i)];
        return w;
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [2:0] f3);
        int n;
        logic [63:0] v;
        n = 1 << f3[1:0];
        v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(refmem[8'(int'(a[7:0]) + i)]) << (8 * i));
        if (!f3[2] && (n < 8) && v[8*n-1]) v = v - (64'd1 << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input logic [2:0] f3, input logic [63:0] wd);
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) refmem[8'(int'(a[7:0]) + i)] = wd[8*i +: 8];
    endtask

    task automatic preload(input logic [4:0] idx, input logic [63:0] d);
        pl_we = 1'b1; pl_idx = idx; pl_data = d;
        for (int i = 0; i < 8; i++) refmem[{idx, 3'(i)}] = d[8*i +: 8];
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // Issue one request at posedge+1 and follow it to completion; returns at posedge+1.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        int   n;
        int   kind;
        logic legal;
        logic mis;
        n     = 1 << f3[1:0];
        legal = we ? (f3[2] == 1'b0) : (f3 != 3'b111);
        mis   = legal && ((int'(a[2:0]) % n) != 0);
        if (!legal) kind = 0;
        else if (mis) kind = 1;
        else if (we && n == 8) kind = 2;
        else if (we) kind = 3;
        else kind = 4;
        req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        chk("load_valid_pulse", 64'(load_valid), 64'(prev_lv));
        chk("misaligned_pulse", 64'(misaligned), 64'(prev_mis));
        chk("accept_stall", 64'(stall), 64'(kind >= 3));
        chk("accept_mem_we", 64'(mem_we), 64'(kind == 2));
        if (kind == 2) begin
            chk("sd_mem_wd", mem_wd, wd);
            chk("sd_mem_addr", mem_addr, a);
            obs_wd = mem_wd;
            ref_store(a, f3, wd);
        end else begin
            chk("idle_mem_wd_zero", mem_wd, 64'd0);
            if (kind >= 3) chk("accept_mem_addr", mem_addr, a);
        end
        if (kind >= 3) begin
            if (kind == 3) ref_store(a, f3, wd);
            @(posedge clk); #1;
            req_valid = 1'b1;
            req_we    = 1'($urandom);
            funct3    = 3'($urandom);
            addr      = {$urandom, $urandom};
            wdata     = {$urandom, $urandom};
            @(negedge clk);
            chk("second_stall", 64'(stall), 64'd0);
            chk("second_mem_addr", mem_addr, a);
            if (kind == 3) begin
                chk("rmw_mem_we", 64'(mem_we), 64'd1);
                chk("rmw_mem_wd", mem_wd, ref_word(a));
                obs_wd = mem_wd;
            end else begin
                chk("ldwait_mem_we", 64'(mem_we), 64'd0);
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (kind == 4) begin
                last_ld = ref_load(a, f3);
                chk("ld_valid", 64'(load_valid), 64'd1);
                chk("ld_data", load_data, last_ld);
            end else begin
                chk("st_no_valid", 64'(load_valid), 64'd0);
            end
        end else begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk("fault_pulse", 64'(misaligned), 64'(kind == 1));
            chk("no_load_valid", 64'(load_valid), 64'd0);
            chk("load_data_hold", load_data, last_ld);
        end
        prev_lv  = (kind == 4);
        prev_mis = (kind == 1);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] wd;
        logic [1:0]  what;
        logic [63:0] exp;
    } vec_t;

    vec_t vt [20];

    initial begin
        total = 0; bad = 0;
        last_ld = 64'd0; obs_wd = 64'd0; prev_lv = 1'b0; prev_mis = 1'b0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'd0;
        addr = 64'd0; wdata = 64'd0;
        pl_we = 1'b0; pl_idx = 5'd0; pl_data = 64'd0;

        // what: 0 = model checks only, 1 = load_data, 2 = write word seen on mem_wd
        vt[0]  = '{1'b1, 3'b000, 64'h13, 64'hAB,               2'd2, 64'h1122_3344_AB66_7788};
        vt[1]  = '{1'b0, 3'b000, 64'h14, 64'h0,                2'd1, 64'h0000_0000_0000_0044};
        vt[2]  = '{1'b0, 3'b100, 64'h14, 64'h0,                2'd1, 64'h0000_0000_0000_0044};
        vt[3]  = '{1'b0, 3'b000, 64'h13, 64'h0,                2'd1, 64'hFFFF_FFFF_FFFF_FFAB};
        vt[4]  = '{1'b0, 3'b100, 64'h13, 64'h0,                2'd1, 64'h0000_0000_0000_00AB};
        vt[5]  = '{1'b0, 3'b000, 64'h17, 64'h0,                2'd1, 64'h0000_0000_0000_0011};
        vt[6]  = '{1'b1, 3'b000, 64'h17, 64'h80,               2'd2, 64'h8022_3344_AB66_7788};
        vt[7]  = '{1'b0, 3'b000, 64'h17, 64'h0,                2'd1, 64'hFFFF_FFFF_FFFF_FF80};
        vt[8]  = '{1'b0, 3'b100, 64'h17, 64'h0,                2'd1, 64'h0000_0000_0000_0080};
        vt[9]  = '{1'b1, 3'b011, 64'h20, 64'hDEAD_BEEF_CAFE_F00D, 2'd2, 64'hDEAD_BEEF_CAFE_F00D};
        vt[10] = '{1'b0, 3'b011, 64'h20, 64'h0,                2'd1, 64'hDEAD_BEEF_CAFE_F00D};
        vt[11] = '{1'b0, 3'b010, 64'h22, 64'h0,                2'd1, 64'hDEAD_BEEF_CAFE_F00D};
        vt[12] = '{1'b1, 3'b010, 64'h44, 64'h89AB_CDEF,        2'd0, 64'h0};
        vt[13] = '{1'b0, 3'b110, 64'h44, 64'h0,                2'd1, 64'h0000_0000_89AB_CDEF};
        vt[14] = '{1'b0, 3'b010, 64'h44, 64'h0,                2'd1, 64'hFFFF_FFFF_89AB_CDEF};
        vt[15] = '{1'b0, 3'b001, 64'h46, 64'h0,                2'd1, 64'hFFFF_FFFF_FFFF_89AB};
        vt[16] = '{1'b0, 3'b111, 64'h40, 64'h0,                2'd1, 64'hFFFF_FFFF_FFFF_89AB};
        vt[17] = '{1'b1, 3'b100, 64'h40, 64'h1234,             2'd0, 64'h0};
        vt[18] = '{1'b0, 3'b101, 64'h46, 64'h0,                2'd1, 64'h0000_0000_0000_89AB};
        vt[19] = '{1'b1, 3'b001, 64'h31, 64'h5555,             2'd0, 64'h0};

        for (int i = 0; i < 32; i++) preload(5'(i), {$urandom, $urandom});
        preload(5'h02, 64'h1122_3344_5566_7788);

        @(negedge clk);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_load_data", load_data, 64'd0);
        chk("rst_load_valid", 64'(load_valid), 64'd0);
        chk("rst_misaligned", 64'(misaligned), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            do_req(vt[i].we, vt[i].f3, vt[i].a, vt[i].wd);
            if (vt[i].what == 2'd1) chk($sformatf("vec%0d_load", i), load_data, vt[i].exp);
            if (vt[i].what == 2'd2) chk($sformatf("vec%0d_wd", i), obs_wd, vt[i].exp);
        end

        // Reset during the RMW_WRITE cycle of SH 0x30 must abort the write.
        req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b001; addr = 64'h30; wdata = 64'hBEEF;
        @(negedge clk);
        chk("sh_accept_stall", 64'(stall), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_we", 64'(mem_we), 64'd0);
        chk("abort_stall", 64'(stall), 64'd0);
        @(negedge clk);
        chk("abort_load_data", load_data, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_ld = 64'd0; prev_lv = 1'b0; prev_mis = 1'b0;
        chk("abort_word_kept", tmem[6], ref_word(64'h30));
        do_req(1'b0, 3'b011, 64'h30, 64'h0);
        chk("abort_ld_readback", load_data, ref_word(64'h30));

        for (int i = 0; i < 150; i++) begin
            do_req(1'($urandom), 3'($urandom), {$urandom, 24'($urandom), 8'($urandom)},
                   {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
